// File: rtl/game_state_sequencer_pkg.sv
// rtl/game_state_sequencer_pkg.sv - shared state codes and widths for the game state path
// Used by game_state_sequencer and the seven-segment state decoder so the
// display codes are defined in exactly one place.
package game_state_sequencer_pkg;

  localparam int STATE_W = 3;
  localparam int SCORE_W = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_HOME  = 3'b001,
    ST_PLAY  = 3'b010,
    ST_SCORE = 3'b011,
    ST_FAIL  = 3'b100
  } state_e;

  function automatic logic is_legal_state(input logic [STATE_W-1:0] s);
    return (s == ST_HOME) || (s == ST_PLAY) || (s == ST_SCORE) || (s == ST_FAIL);
  endfunction

endpackage

// File: rtl/game_state_sequencer_btn_sync_edge.sv
// rtl/game_state_sequencer_btn_sync_edge.sv - button synchronizer, rising-edge detect and lockout
// Ports:
//   clk     in  system clock
//   reset   in  asynchronous active-high reset
//   btn_raw in  raw button level, asynchronous to clk
//   press   out one-cycle accepted press pulse (combinational from flops)
module btn_sync_edge #(
  parameter int LOCKOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES - 1);

  // sync_q[0], sync_q[1]: two-flop synchronizer; sync_q[2]: previous synced level
  logic [2:0]        sync_q, sync_d;
  logic [LOCK_W-1:0] lock_q, lock_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      lock_q <= '0;
    end else begin
      sync_q <= sync_d;
      lock_q <= lock_d;
    end
  end

  always_comb begin
    sync_d = {sync_q[1:0], btn_raw};
    press  = sync_q[1] & ~sync_q[2] & (lock_q == '0);
    lock_d = lock_q;
    if (press)
      lock_d = LOCK_LOAD;
    else if (lock_q != '0)
      lock_d = lock_q - LOCK_W'(1);
  end

endmodule

// File: rtl/game_state_sequencer.sv
// rtl/game_state_sequencer.sv - HOME/PLAY/SCORE/FAIL sequencer driving the display state bus
// Ports:
//   clk          in  system clock
//   reset        in  asynchronous active-high reset
//   btn_start    in  raw start/acknowledge button
//   btn_hit      in  raw hit button
//   state        out display state code (001/010/011/100 only)
//   score        out current hit count
//   state_change out one-cycle pulse in the first cycle of a new state value
module game_state_sequencer
  import game_state_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int HOLD_CYCLES    = 200_000_000,
  parameter int WIN_SCORE      = 10,
  parameter int LOCKOUT_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_start,
  input  logic               btn_hit,
  output logic [STATE_W-1:0] state,
  output logic [SCORE_W-1:0] score,
  output logic               state_change
);

  localparam int TMR_MAX = (TIMEOUT_CYCLES > HOLD_CYCLES) ? TIMEOUT_CYCLES : HOLD_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0]   TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0]   HOLD_LAST    = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL      = SCORE_W'(WIN_SCORE);

  logic start_press, hit_press;

  btn_sync_edge #(.LOCKOUT_CYCLES(LOCKOUT_CYCLES)) u_start_sync (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_start),
    .press   (start_press)
  );

  btn_sync_edge #(.LOCKOUT_CYCLES(LOCKOUT_CYCLES)) u_hit_sync (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_hit),
    .press   (hit_press)
  );

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d, score_inc;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               state_change_q, state_change_d;

  // One timer serves both PLAY (hit timeout) and SCORE/FAIL (hold);
  // every state transition clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_HOME;
      score_q        <= '0;
      timer_q        <= '0;
      state_change_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      score_q        <= score_d;
      timer_q        <= timer_d;
      state_change_q <= state_change_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    timer_d   = timer_q;
    score_inc = score_q + SCORE_W'(1);
    case (state_q)
      ST_HOME: begin
        score_d = '0;
        timer_d = '0;
        if (start_press)
          state_d = ST_PLAY;
      end
      ST_PLAY: begin
        // A hit in the timeout cycle takes priority over the timeout.
        if (hit_press) begin
          score_d = score_inc;
          timer_d = '0;
          if (score_inc == WIN_VAL)
            state_d = ST_SCORE;
        end else if (timer_q == TIMEOUT_LAST) begin
          state_d = ST_FAIL;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_SCORE, ST_FAIL: begin
        if (start_press || (timer_q == HOLD_LAST)) begin
          state_d = ST_HOME;
          score_d = '0;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = ST_HOME;
        score_d = '0;
        timer_d = '0;
      end
    endcase
    // Compare against what is displayed so an illegal code (shown as HOME)
    // recovering to HOME does not pulse.
    state_change_d = (state_d != state);
  end

  always_comb begin
    state        = is_legal_state(state_q) ? state_q : ST_HOME;
    score        = score_q;
    state_change = state_change_q;
  end

endmodule

// File: tb/tb_game_state_sequencer.sv
// tb/tb_game_state_sequencer.sv - directed self-checking bench for game_state_sequencer
module tb_game_state_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_hit = 1'b0;
  logic [2:0] state;
  logic [7:0] score;
  logic       state_change;

  int checks = 0;
  int failures = 0;

  game_state_sequencer #(
    .TIMEOUT_CYCLES (20),
    .HOLD_CYCLES    (30),
    .WIN_SCORE      (3),
    .LOCKOUT_CYCLES (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_start    (btn_start),
    .btn_hit      (btn_hit),
    .state        (state),
    .score        (score),
    .state_change (state_change)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raw high for exactly one edge; the sequencer reacts two edges later.
  task automatic pulse_start();
    btn_start = 1'b1;
    tick(1);
    btn_start = 1'b0;
  endtask

  task automatic pulse_hit();
    btn_hit = 1'b1;
    tick(1);
    btn_hit = 1'b0;
  endtask

  // HOME -> PLAY; returns right after the entry edge.
  task automatic enter_play(input string tag);
    pulse_start();
    tick(1);
    check({tag, "_pre"}, state, 3'b001);
    tick(1);
    check({tag, "_play"}, state, 3'b010);
    check({tag, "_chg"}, state_change, 1'b1);
  endtask

  initial begin
    // Power-on reset
    tick(2);
    check("rst_state", state, 3'b001);
    check("rst_score", score, 8'd0);
    check("rst_chg", state_change, 1'b0);
    reset = 1'b0;
    tick(3);
    check("post_rst_state", state, 3'b001);
    check("post_rst_chg", state_change, 1'b0);

    // Start held: enter PLAY once, timeout to FAIL at +20, hold to HOME at +30,
    // and the still-held level never re-fires.
    btn_start = 1'b1;
    tick(2);
    check("start_k1", state, 3'b001);
    tick(1);
    check("start_k2_state", state, 3'b010);
    check("start_k2_chg", state_change, 1'b1);
    tick(1);
    check("start_chg_once", state_change, 1'b0);
    tick(18);
    check("play_t19", state, 3'b010);
    tick(1);
    check("fail_at_20", state, 3'b100);
    check("fail_chg", state_change, 1'b1);
    check("fail_score", score, 8'd0);
    tick(29);
    check("fail_hold29", state, 3'b100);
    tick(1);
    check("hold_home", state, 3'b001);
    tick(10);
    check("held_no_refire", state, 3'b001);
    btn_start = 1'b0;
    tick(3);

    // Start press in FAIL returns HOME at +2 latency
    enter_play("t4");
    tick(19);
    check("t4_play19", state, 3'b010);
    tick(1);
    check("t4_fail", state, 3'b100);
    tick(2);
    pulse_start();
    tick(1);
    check("t4_fail_pre", state, 3'b100);
    tick(1);
    check("t4_home", state, 3'b001);
    check("t4_home_chg", state_change, 1'b1);

    // Three hits 8 cycles apart -> SCORE, then 30-cycle hold -> HOME
    tick(3);
    enter_play("t3");
    tick(2);
    for (int h = 1; h <= 3; h++) begin
      pulse_hit();
      tick(1);
      check("t3_hit_pre", score, 8'(h - 1));
      tick(1);
      check("t3_score", score, 8'(h));
      check("t3_state", state, (h == 3) ? 3'b011 : 3'b010);
      if (h < 3) tick(5);
    end
    check("t3_win_chg", state_change, 1'b1);
    tick(29);
    check("t3_hold29_state", state, 3'b011);
    check("t3_frozen", score, 8'd3);
    tick(1);
    check("t3_home", state, 3'b001);
    check("t3_home_score", score, 8'd0);

    // Hit press in the cycle the timer is 19: hit wins, timer restarts
    tick(3);
    enter_play("t5");
    tick(17);
    pulse_hit();
    tick(1);
    check("t5_pre", score, 8'd0);
    tick(1);
    check("t5_score", score, 8'd1);
    check("t5_state", state, 3'b010);
    tick(19);
    check("t5_restart19", state, 3'b010);
    tick(1);
    check("t5_fail", state, 3'b100);
    check("t5_fail_score", score, 8'd1);
    tick(30);
    check("t5_home", state, 3'b001);

    // Bounce 1,0,1 -> one increment; clean press 5 cycles later counts
    tick(3);
    enter_play("t6");
    btn_hit = 1'b1;
    tick(1);
    btn_hit = 1'b0;
    tick(1);
    btn_hit = 1'b1;
    tick(1);
    check("t6_first", score, 8'd1);
    btn_hit = 1'b0;
    tick(2);
    check("t6_bounce_drop", score, 8'd1);
    btn_hit = 1'b1;
    tick(1);
    btn_hit = 1'b0;
    tick(1);
    check("t6_second_pre", score, 8'd1);
    tick(1);
    check("t6_second", score, 8'd2);
    check("t6_state", state, 3'b010);

    // Asynchronous reset mid-PLAY with score=2
    #3;
    reset = 1'b1;
    #1;
    check("t1_async_state", state, 3'b001);
    check("t1_async_score", score, 8'd0);
    check("t1_async_chg", state_change, 1'b0);
    tick(2);
    #2;
    reset = 1'b0;
    tick(4);
    check("t1_release_state", state, 3'b001);
    check("t1_release_chg", state_change, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_state_sequencer.md
Name: game_state_sequencer

Overview:
- Sequential controller that generates the 3-bit display state code consumed by the downstream seven-segment state decoder.
- Display mapping: 001=H (HOME), 010=P (PLAY), 011=S (SCORE), 100=F (FAIL).
- Takes two raw push-buttons and steps through HOME -> PLAY -> SCORE/FAIL -> HOME. Also tracks a hit score and a play timeout.
- Sits between the board buttons and the display path; it is the sole writer of the state bus.

Parameters:
- TIMEOUT_CYCLES, 100_000_000: cycles allowed in PLAY between hits before FAIL.
- HOLD_CYCLES, 200_000_000: cycles SCORE/FAIL is held before automatic return to HOME.
- WIN_SCORE, 10: hit count that ends PLAY with SCORE; range 1..255.
- LOCKOUT_CYCLES, 1_000_000: per-button ignore window after an accepted press (bounce rejection).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- btn_start  in  1  raw start/acknowledge button, asynchronous to clk.
- btn_hit  in  1  raw hit button, asynchronous to clk.
- state  out  3  display state code; only 001/010/011/100 are ever driven.
- score  out  8  current hit count, unsigned.
- state_change  out  1  one-cycle pulse, high in the first cycle a new state value is on state.

Behaviour:
- Reset (async assert, sync release):
  - state=001, score=0, state_change=0.
  - Timers, sync flops and lockout counters all 0.
- Button path, per button:
  - 2-flop synchronizer, then a third flop for rising-edge detect.
  - Accepted press = sync2 & ~sync3 & (lockout counter == 0).
  - An accepted press loads the lockout counter with LOCKOUT_CYCLES-1; it decrements to 0 each cycle.
  - Edges arriving during lockout are dropped; the level being held never re-fires.
- Latency: button high before edge k -> press pulse during cycle after edge k+1 -> state/score updated at edge k+2.
- HOME (001):
  - score held at 0, play timer 0.
  - start press -> PLAY. hit press ignored.
- PLAY (010):
  - play timer increments every cycle.
  - hit press: score+1 and play timer cleared to 0.
  - If the new score == WIN_SCORE -> SCORE on that same edge.
  - Timer reaches TIMEOUT_CYCLES-1 with no hit in that cycle -> FAIL.
  - Hit and timeout in the same cycle: hit wins, no FAIL.
  - start press ignored.
- SCORE (011) / FAIL (100):
  - score frozen, hold timer counts.
  - Hold timer == HOLD_CYCLES-1, or start press -> HOME, which clears score to 0 on entry.
  - hit press ignored.
- Illegal internal state value -> HOME on the next edge; state output still never shows an illegal code.
- state_change: registered; 1 exactly when state differs from its previous-cycle value. Deasserts after reset.
- Timers are wide enough for max(TIMEOUT_CYCLES, HOLD_CYCLES). score never exceeds WIN_SCORE.
- Reset mid-operation: immediate return to reset values; no pending press survives.

Decomposition:
- Shared package:
  - State-code constants ST_HOME=3'b001, ST_PLAY=3'b010, ST_SCORE=3'b011, ST_FAIL=3'b100.
  - STATE_W=3 and SCORE_W=8.
  - Used by this block and the seven-segment state decoder so the codes cannot diverge.
- Sub-module btn_sync_edge: synchronizer, edge detect and lockout counter. Parameter LOCKOUT_CYCLES; ports clk, reset, btn_raw, press. Instantiated twice.
- FSM, timers and score stay in the top module.

Test Plan (TIMEOUT_CYCLES=20, HOLD_CYCLES=30, WIN_SCORE=3, LOCKOUT_CYCLES=4):
1. Reset asserted mid-PLAY with score=2 -> state=001, score=0, state_change=0 immediately and asynchronously. Release -> stays 001.
2. btn_start pulse before edge k in HOME -> state=010 after edge k+2, state_change=1 for exactly that cycle. start held high 50 cycles -> no further change.
3. Three hit presses spaced 8 cycles apart in PLAY:
   - score steps 1,2,3.
   - state=011 on the edge where score becomes 3.
   - 30 cycles later state=001 and score=0.
4. PLAY with no hit -> state=100 exactly 20 cycles after PLAY entry. A start press during FAIL -> 001 at the +2-edge latency.
5. Hit press lands in the same cycle the timer reaches 19 -> score increments, timer clears, state stays 010.
6. Bouncing btn_hit (toggling 1,0,1 across 3 cycles) -> single score increment. A second clean press 5 cycles after the first accepted one -> increment.
